// File: rtl/fetch_phase_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_phase_unit
// Function : PC, fetch register, phase flop and C/Z flags for the microcode
//            sequencer; assembles rom_addr = {instr, c_flag, z_flag, phase}.
//            Optional macro PC_WRAP_FLAG_EN adds the sticky pc_wrapped output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_phase_unit #(
  parameter int PC_WIDTH = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          program_byte,
  input  logic                inc_pc,
  input  logic                load_pc,
  input  logic [PC_WIDTH-1:0] load_data,
  input  logic                load_flags,
  input  logic                carry_in,
  input  logic                zero_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          instr,
  output logic [3:0]          oprnd,
  output logic                phase,
  output logic                c_flag,
  output logic                z_flag,
  output logic [6:0]          rom_addr
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic                pc_wrapped
`endif
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          instr_q, instr_d;
  logic [3:0]          oprnd_q, oprnd_d;
  logic                phase_q, phase_d;
  logic                c_flag_q, c_flag_d;
  logic                z_flag_q, z_flag_d;
  logic                wrap_evt;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    oprnd_d  = oprnd_q;
    phase_d  = phase_q;
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    wrap_evt = 1'b0;
    if (enable) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        instr_d = program_byte[7:4];
        oprnd_d = program_byte[3:0];
      end
      // Load outranks increment; the increment wraps naturally modulo 2^PC_WIDTH.
      if (load_pc) begin
        pc_d = load_data;
      end else if (inc_pc) begin
        pc_d     = pc_q + PC_WIDTH'(1);
        wrap_evt = &pc_q;
      end
      if (load_flags) begin
        c_flag_d = carry_in;
        z_flag_d = zero_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      oprnd_q  <= '0;
      phase_q  <= 1'b0;
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      oprnd_q  <= oprnd_d;
      phase_q  <= phase_d;
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

`ifdef PC_WRAP_FLAG_EN
  logic pc_wrapped_q, pc_wrapped_d;

  always_comb begin
    pc_wrapped_d = pc_wrapped_q | wrap_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_wrapped_q <= 1'b0;
    end else begin
      pc_wrapped_q <= pc_wrapped_d;
    end
  end

  assign pc_wrapped = pc_wrapped_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_evt;
`endif

  assign pc       = pc_q;
  assign instr    = instr_q;
  assign oprnd    = oprnd_q;
  assign phase    = phase_q;
  assign c_flag   = c_flag_q;
  assign z_flag   = z_flag_q;
  assign rom_addr = {instr_q, c_flag_q, z_flag_q, phase_q};

endmodule
`default_nettype wire

// File: tb/tb_fetch_phase_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_phase_unit
// Function : Directed bench for fetch_phase_unit (optionally PC_WRAP_FLAG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_phase_unit;

  localparam int PC_WIDTH = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [7:0]          program_byte;
  logic                inc_pc;
  logic                load_pc;
  logic [PC_WIDTH-1:0] load_data;
  logic                load_flags;
  logic                carry_in;
  logic                zero_in;
  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          instr;
  logic [3:0]          oprnd;
  logic                phase;
  logic                c_flag;
  logic                z_flag;
  logic [6:0]          rom_addr;
`ifdef PC_WRAP_FLAG_EN
  logic                pc_wrapped;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_phase_unit #(.PC_WIDTH(PC_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .program_byte (program_byte),
    .inc_pc       (inc_pc),
    .load_pc      (load_pc),
    .load_data    (load_data),
    .load_flags   (load_flags),
    .carry_in     (carry_in),
    .zero_in      (zero_in),
    .pc           (pc),
    .instr        (instr),
    .oprnd        (oprnd),
    .phase        (phase),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .rom_addr     (rom_addr)
`ifdef PC_WRAP_FLAG_EN
    ,
    .pc_wrapped   (pc_wrapped)
`endif
  );

  always #5 clk = ~clk;

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable       = 1'b0;
    program_byte = 8'h00;
    inc_pc       = 1'b0;
    load_pc      = 1'b0;
    load_data    = '0;
    load_flags   = 1'b0;
    carry_in     = 1'b0;
    zero_in      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    enable       = 1'b1;
    inc_pc       = 1'b1;
    program_byte = 8'hFF;
    load_flags   = 1'b1;
    carry_in     = 1'b1;
    zero_in      = 1'b1;
    reset        = 1'b1;
    step();
    n_vec++;
    if ({pc, instr, oprnd, phase, c_flag, z_flag} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h instr=%h oprnd=%h ph=%b c=%b z=%b, want all 0",
               pc, instr, oprnd, phase, c_flag, z_flag);
    end
    n_vec++;
    if (rom_addr !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset_rom_addr: got %b want 0000000", rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    enable       = 1'b1;
    program_byte = 8'hA5;
    step();
    n_vec++;
    if ({phase, instr, oprnd} !== {1'b1, 4'hA, 4'h5}) begin
      n_err++;
      $display("FAIL fetch_edge1: got ph=%b instr=%h oprnd=%h, want 1 A 5", phase, instr, oprnd);
    end
    n_vec++;
    if (rom_addr !== 7'b1010001) begin
      n_err++;
      $display("FAIL fetch_rom_addr: got %b want 1010001", rom_addr);
    end
    program_byte = 8'h3C;
    step();
    n_vec++;
    if ({phase, instr, oprnd} !== {1'b0, 4'hA, 4'h5}) begin
      n_err++;
      $display("FAIL fetch_edge2_hold: got ph=%b instr=%h oprnd=%h, want 0 A 5", phase, instr, oprnd);
    end
    step();
    n_vec++;
    if ({phase, instr, oprnd} !== {1'b1, 4'h3, 4'hC}) begin
      n_err++;
      $display("FAIL fetch_edge3: got ph=%b instr=%h oprnd=%h, want 1 3 C", phase, instr, oprnd);
    end
  endtask

  task automatic test_pc_inc_load();
    do_reset();
    enable = 1'b1;
    inc_pc = 1'b1;
    repeat (5) step();
    n_vec++;
    if (pc !== 12'd5) begin
      n_err++;
      $display("FAIL pc_inc5: got %h want 005", pc);
    end
    load_pc   = 1'b1;
    load_data = 12'h3F0;
    step();
    n_vec++;
    if (pc !== 12'h3F0) begin
      n_err++;
      $display("FAIL pc_load_priority: got %h want 3F0", pc);
    end
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    step();
    n_vec++;
    if (pc !== 12'h3F0) begin
      n_err++;
      $display("FAIL pc_hold: got %h want 3F0", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    enable    = 1'b1;
    load_pc   = 1'b1;
    load_data = 12'hFFF;
    step();
    n_vec++;
    if (pc !== 12'hFFF) begin
      n_err++;
      $display("FAIL wrap_load: got %h want FFF", pc);
    end
`ifdef PC_WRAP_FLAG_EN
    n_vec++;
    if (pc_wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_flag_pre: got %b want 0", pc_wrapped);
    end
`endif
    load_pc = 1'b0;
    inc_pc  = 1'b1;
    step();
    n_vec++;
    if (pc !== 12'h000) begin
      n_err++;
      $display("FAIL wrap_pc: got %h want 000", pc);
    end
    inc_pc    = 1'b0;
    load_pc   = 1'b1;
    load_data = 12'h000;
    step();
    load_pc = 1'b0;
    step();
`ifdef PC_WRAP_FLAG_EN
    n_vec++;
    if (pc_wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_flag_sticky: got %b want 1", pc_wrapped);
    end
    do_reset();
    n_vec++;
    if (pc_wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_flag_reset: got %b want 0", pc_wrapped);
    end
    // A load to zero is not a wrap.
    enable    = 1'b1;
    load_pc   = 1'b1;
    load_data = 12'h000;
    step();
    n_vec++;
    if (pc_wrapped !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_flag_load0: got %b want 0", pc_wrapped);
    end
`endif
  endtask

  task automatic test_flags();
    do_reset();
    enable       = 1'b1;
    program_byte = 8'h83;
    load_flags   = 1'b1;
    carry_in     = 1'b1;
    zero_in      = 1'b0;
    step();
    n_vec++;
    if ({instr, phase, c_flag, z_flag} !== {4'h8, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL flags_load: got instr=%h ph=%b c=%b z=%b, want 8 1 1 0",
               instr, phase, c_flag, z_flag);
    end
    n_vec++;
    if (rom_addr !== 7'b1000101) begin
      n_err++;
      $display("FAIL flags_rom_addr: got %b want 1000101", rom_addr);
    end
    load_flags = 1'b0;
    carry_in   = 1'b0;
    zero_in    = 1'b1;
    step();
    n_vec++;
    if ({c_flag, z_flag, rom_addr} !== {1'b1, 1'b0, 7'b1000100}) begin
      n_err++;
      $display("FAIL flags_hold: got c=%b z=%b rom=%b, want 1 0 1000100", c_flag, z_flag, rom_addr);
    end
    load_flags = 1'b1;
    step();
    n_vec++;
    if ({c_flag, z_flag} !== 2'b01) begin
      n_err++;
      $display("FAIL flags_reload: got c=%b z=%b, want 0 1", c_flag, z_flag);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    enable       = 1'b1;
    program_byte = 8'h6B;
    inc_pc       = 1'b1;
    load_flags   = 1'b1;
    carry_in     = 1'b1;
    zero_in      = 1'b1;
    step();
    // State now: pc=1, phase=1, instr=6, oprnd=B, c=1, z=1
    enable     = 1'b0;
    carry_in   = 1'b0;
    zero_in    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      program_byte = 8'h10 + 8'(i);
      step();
      n_vec++;
      if ({pc, phase, instr, oprnd, c_flag, z_flag} !==
          {12'h001, 1'b1, 4'h6, 4'hB, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL enable_hold[%0d]: got pc=%h ph=%b instr=%h oprnd=%h c=%b z=%b, want 001 1 6 B 1 1",
                 i, pc, phase, instr, oprnd, c_flag, z_flag);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable       = 1'b1;
    program_byte = 8'h12;
    inc_pc       = 1'b1;
    load_flags   = 1'b1;
    carry_in     = 1'b1;
    repeat (7) step();
    n_vec++;
    if ({pc, phase, c_flag} !== {12'd7, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL midrun_state: got pc=%h ph=%b c=%b, want 007 1 1", pc, phase, c_flag);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if ({pc, instr, oprnd, phase, c_flag, z_flag, rom_addr} !== 30'd0) begin
      n_err++;
      $display("FAIL midrun_reset: got pc=%h instr=%h oprnd=%h ph=%b c=%b z=%b rom=%b, want all 0",
               pc, instr, oprnd, phase, c_flag, z_flag, rom_addr);
    end
    inc_pc       = 1'b0;
    load_flags   = 1'b0;
    carry_in     = 1'b0;
    program_byte = 8'h5C;
    step();
    n_vec++;
    if ({pc, phase, instr, oprnd} !== {12'd0, 1'b1, 4'h5, 4'hC}) begin
      n_err++;
      $display("FAIL restart_fetch: got pc=%h ph=%b instr=%h oprnd=%h, want 000 1 5 C",
               pc, phase, instr, oprnd);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_fetch();
    test_pc_inc_load();
    test_wrap();
    test_flags();
    test_enable_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
